// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped write-back write-allocate data cache controller.
//   clk_i/rst_i            clock, async active-low reset
//   cpu_*                  single-cycle CPU load/store port, cpu_stall_o holds the CPU on a miss
//   mem_*                  word-wide req/ack memory port used for write-back and refill bursts
//   hit_count_o/miss_count_o  access statistics, present only with DCACHE_STATS_EN defined
module dcache_ctrl #(
   parameter int INDEX_BITS     = 4,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] cpu_addr_i,
   input  logic [31:0] cpu_data_i,
   input  logic        cpu_read_i,
   input  logic        cpu_write_i,
   output logic [31:0] cpu_data_o,
   output logic        cpu_stall_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_data_o,
   input  logic [31:0] mem_data_i,
   input  logic        mem_ack_i
`ifdef DCACHE_STATS_EN
  ,output logic [31:0] hit_count_o,
   output logic [31:0] miss_count_o
`endif
);
   localparam int LINES    = 1 << INDEX_BITS;
   localparam int TAG_BITS = 28 - INDEX_BITS;
   localparam logic [1:0] LAST = 2'(WORDS_PER_LINE - 1);
   typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL} state_t;
   state_t state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic [LINES-1:0] valid_q, valid_d, dirty_q, dirty_d;
   logic [WORDS_PER_LINE-1:0][31:0] data_q [LINES];
   logic [TAG_BITS-1:0] tag_q [LINES];
   logic [INDEX_BITS-1:0] idx;
   logic [TAG_BITS-1:0] atag;
   logic [1:0] word;
   logic access, hit, data_we, tag_we, unused_ok;
   logic [1:0] data_word;
   logic [31:0] data_wdata;
   assign idx       = cpu_addr_i[3+INDEX_BITS:4];
   assign atag      = cpu_addr_i[31:4+INDEX_BITS];
   assign word      = cpu_addr_i[3:2];
   assign unused_ok = ^cpu_addr_i[1:0];
   assign access    = cpu_read_i | cpu_write_i;
   assign hit       = valid_q[idx] & (tag_q[idx] == atag);
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      valid_d     = valid_q;
      dirty_d     = dirty_q;
      data_we     = 1'b0;
      data_word   = word;
      data_wdata  = cpu_data_i;
      tag_we      = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_data_o  = '0;
      cpu_stall_o = 1'b0;
      cpu_data_o  = '0;
      case (state_q)
         S_IDLE: begin
            if (access && hit) begin
               if (cpu_write_i) begin
                  data_we      = 1'b1;
                  dirty_d[idx] = 1'b1;
               end else begin
                  cpu_data_o = data_q[idx][word];
               end
            end else if (access) begin
               cpu_stall_o = 1'b1;
               cnt_d       = '0;
               state_d     = (valid_q[idx] && dirty_q[idx]) ? S_WB : S_FILL;
            end
         end
         S_WB: begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = {tag_q[idx], idx, cnt_q, 2'b00};
            mem_data_o  = data_q[idx][cnt_q];
            cpu_stall_o = 1'b1;
            if (mem_ack_i) begin
               cnt_d = cnt_q + 2'd1;
               if (cnt_q == LAST) begin
                  dirty_d[idx] = 1'b0;
                  state_d      = S_FILL;
               end
            end
         end
         S_FILL: begin
            mem_req_o   = 1'b1;
            mem_addr_o  = {atag, idx, cnt_q, 2'b00};
            cpu_stall_o = 1'b1;
            if (mem_ack_i) begin
               data_we    = 1'b1;
               data_word  = cnt_q;
               data_wdata = mem_data_i;
               cnt_d      = cnt_q + 2'd1;
               if (cnt_q == LAST) begin
                  tag_we       = 1'b1;
                  valid_d[idx] = 1'b1;
                  dirty_d[idx] = 1'b0;
                  state_d      = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      // A pending miss must not stall the CPU while the cache is held in reset
      if (!rst_i) cpu_stall_o = 1'b0;
   end
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end
   // Data and tag storage carries no reset; valid bits guard its contents
   always_ff @(posedge clk_i) begin
      if (data_we) data_q[idx][data_word] <= data_wdata;
      if (tag_we) tag_q[idx] <= atag;
   end
`ifdef DCACHE_STATS_EN
   logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
   logic retry_q, retry_d;
   // retry_q marks the cycle right after a refill, whose hit belongs to the miss
   always_comb begin
      retry_d    = (state_q == S_FILL) && mem_ack_i && (cnt_q == LAST);
      hit_cnt_d  = hit_cnt_q + 32'((state_q == S_IDLE) && access && hit && !retry_q && !(&hit_cnt_q));
      miss_cnt_d = miss_cnt_q + 32'((state_q == S_IDLE) && access && !hit && !(&miss_cnt_q));
   end
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         retry_q    <= 1'b0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
         retry_q    <= retry_d;
      end
   end
   assign hit_count_o  = hit_cnt_q;
   assign miss_count_o = miss_cnt_q;
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// tb_dcache_ctrl: directed self-checking bench for dcache_ctrl with a 2-cycle-ack memory model.
module tb_dcache_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [31:0] cpu_addr = '0, cpu_wdata = '0;
   logic cpu_read = 1'b0, cpu_write = 1'b0;
   logic [31:0] cpu_rdata, mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic cpu_stall, mem_req, mem_we;
   logic mem_ack = 1'b0;
`ifdef DCACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif
   int n_checks = 0, n_errors = 0;
   logic [31:0] mem [1024];
   logic [31:0] log_a [$];
   logic [31:0] log_d [$];
   logic log_w [$];
   int wc = 0;

   dcache_ctrl dut (
      .clk_i(clk), .rst_i(rst_n),
      .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_wdata),
      .cpu_read_i(cpu_read), .cpu_write_i(cpu_write),
      .cpu_data_o(cpu_rdata), .cpu_stall_o(cpu_stall),
      .mem_req_o(mem_req), .mem_we_o(mem_we),
      .mem_addr_o(mem_addr), .mem_data_o(mem_wdata),
      .mem_data_i(mem_rdata), .mem_ack_i(mem_ack)
`ifdef DCACHE_STATS_EN
     ,.hit_count_o(hit_count), .miss_count_o(miss_count)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   function automatic logic [31:0] init_val(input logic [31:0] a);
      return 32'hC0DE_0000 ^ a;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Memory responder: ack raised two negedges after req is seen, dropped after the ack edge
   always @(negedge clk) begin
      if (!rst_n || !mem_req) begin
         wc = 0;
         mem_ack = 1'b0;
      end else if (mem_ack) begin
         mem_ack = 1'b0;
         wc = 0;
      end else if (wc == 1) begin
         mem_ack = 1'b1;
         mem_rdata = mem[mem_addr[11:2]];
      end else begin
         wc++;
      end
   end

   always @(posedge clk) begin
      if (rst_n && mem_req && mem_ack) begin
         log_a.push_back(mem_addr);
         log_d.push_back(mem_wdata);
         log_w.push_back(mem_we);
         if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
      end
   end

   task automatic clear_log();
      log_a.delete();
      log_d.delete();
      log_w.delete();
   endtask

   task automatic check_burst(input string tag, input int first, input logic [31:0] base, input logic we);
      for (int k = 0; k < 4; k++) begin
         if (first + k < log_a.size()) begin
            check($sformatf("%s_addr%0d", tag, k), log_a[first+k], base + 32'(4 * k));
            check($sformatf("%s_we%0d", tag, k), 32'(log_w[first+k]), 32'(we));
         end
      end
   endtask

   task automatic cpu_op(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] wd,
                         output int stalls, output logic [31:0] rdata);
      @(negedge clk);
      cpu_addr = a;
      cpu_read = rd;
      cpu_write = wr;
      cpu_wdata = wd;
      #1;
      stalls = 0;
      while (cpu_stall && stalls < 500) begin
         @(negedge clk);
         #1;
         stalls++;
      end
      if (stalls >= 500) check("stall_timeout", 32'(stalls), 32'd0);
      rdata = cpu_rdata;
      @(posedge clk);
      #1;
      cpu_read = 1'b0;
      cpu_write = 1'b0;
   endtask

   initial begin
      int st;
      logic [31:0] rd;
      for (int i = 0; i < 1024; i++) mem[i] = init_val(32'(i * 4));
      #1;
      check("rst_stall", 32'(cpu_stall), 32'd0);
      check("rst_req", 32'(mem_req), 32'd0);
      check("rst_we", 32'(mem_we), 32'd0);
      check("rst_addr", mem_addr, 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      check("rst_rdata", cpu_rdata, 32'd0);
      #22 rst_n = 1'b1;

      // 1: cold read miss
      clear_log();
      cpu_op(32'h10, 1'b1, 1'b0, '0, st, rd);
      check("t1_stalled", 32'(st > 4), 32'd1);
      check("t1_nwords", 32'(log_a.size()), 32'd4);
      check_burst("t1", 0, 32'h10, 1'b0);
      check("t1_data", rd, init_val(32'h10));

      // 2: hit read in the same cycle
      clear_log();
      cpu_op(32'h14, 1'b1, 1'b0, '0, st, rd);
      check("t2_stall", 32'(st), 32'd0);
      check("t2_data", rd, init_val(32'h14));
      check("t2_nwords", 32'(log_a.size()), 32'd0);

      // 3: hit write, read-back, then dirty conflict miss
      cpu_op(32'h18, 1'b0, 1'b1, 32'hDEADBEEF, st, rd);
      check("t3_wstall", 32'(st), 32'd0);
      check("t3_wdata_o", rd, 32'd0);
      cpu_op(32'h18, 1'b1, 1'b0, '0, st, rd);
      check("t3_readback", rd, 32'hDEADBEEF);
      check("t3_nomem", 32'(log_a.size()), 32'd0);
      cpu_op(32'h118, 1'b1, 1'b0, '0, st, rd);
      check("t3_nwords", 32'(log_a.size()), 32'd8);
      check_burst("t3wb", 0, 32'h10, 1'b1);
      check_burst("t3fill", 4, 32'h110, 1'b0);
      if (log_d.size() == 8) begin
         check("t3_wb0", log_d[0], init_val(32'h10));
         check("t3_wb1", log_d[1], init_val(32'h14));
         check("t3_wb2", log_d[2], 32'hDEADBEEF);
         check("t3_wb3", log_d[3], init_val(32'h1C));
      end
      check("t3_mem18", mem[32'h18 >> 2], 32'hDEADBEEF);
      check("t3_data", rd, init_val(32'h118));

      // 4: clean conflict, fill only
      clear_log();
      cpu_op(32'h218, 1'b1, 1'b0, '0, st, rd);
      check("t4_nwords", 32'(log_a.size()), 32'd4);
      check_burst("t4", 0, 32'h210, 1'b0);
      check("t4_data", rd, init_val(32'h218));

      // 5: reset in the middle of a refill
      clear_log();
      @(negedge clk);
      cpu_addr = 32'h40;
      cpu_read = 1'b1;
      st = 0;
      while (log_a.size() < 2 && st < 500) begin
         @(posedge clk);
         #1;
         st++;
      end
      check("t5_two_acks", 32'(log_a.size()), 32'd2);
      check("t5_req_before", 32'(mem_req), 32'd1);
      rst_n = 1'b0;
      #1;
      check("t5_req_drop", 32'(mem_req), 32'd0);
      check("t5_stall_drop", 32'(cpu_stall), 32'd0);
      cpu_read = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      clear_log();
      cpu_op(32'h40, 1'b1, 1'b0, '0, st, rd);
      check("t5_nwords", 32'(log_a.size()), 32'd4);
      check_burst("t5", 0, 32'h40, 1'b0);
      check("t5_data", rd, init_val(32'h40));

`ifdef DCACHE_STATS_EN
      // 6: statistics from a fresh reset
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("t6_hit_rst", hit_count, 32'd0);
      check("t6_miss_rst", miss_count, 32'd0);
      cpu_op(32'h10, 1'b1, 1'b0, '0, st, rd);
      cpu_op(32'h10, 1'b1, 1'b0, '0, st, rd);
      cpu_op(32'h14, 1'b1, 1'b0, '0, st, rd);
      cpu_op(32'h18, 1'b1, 1'b0, '0, st, rd);
      cpu_op(32'h118, 1'b1, 1'b0, '0, st, rd);
      check("t6_hits", hit_count, 32'd3);
      check("t6_misses", miss_count, 32'd2);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate data-cache controller between the single-cycle CPU data-memory port and a slow word-wide main memory.
- Owns the tag, valid, dirty and data arrays.
- Serves hits combinationally in the CPU cycle.
- On a miss, asserts cpu_stall_o and runs an optional write-back burst, then a refill burst, through a req/ack handshake.

Parameters:
- INDEX_BITS, 4, line-index width; 2**INDEX_BITS lines.
- WORDS_PER_LINE, 4, fixed 4 words (16 B) per line; word offset is addr[3:2].

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  asynchronous active-low reset
- cpu_addr_i  input  32  byte address; [1:0] ignored, [3:2] word, [3+INDEX_BITS:4] index, [31:4+INDEX_BITS] tag
- cpu_data_i  input  32  store data
- cpu_read_i  input  1  load request
- cpu_write_i  input  1  store request
- cpu_data_o  output  32  load data
- cpu_stall_o  output  1  CPU must hold PC, address and data
- mem_req_o  output  1  memory transfer request
- mem_we_o  output  1  1 = write word, 0 = read word
- mem_addr_o  output  32  word-aligned memory address
- mem_data_o  output  32  write data
- mem_data_i  input  32  read data, valid with mem_ack_i
- mem_ack_i  input  1  transfer completes at this edge

Behaviour:
- Reset, async, rst_i=0:
  - state=IDLE, word counter=0.
  - All valid and dirty bits cleared; data and tag arrays are not reset.
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0, cpu_stall_o=0, cpu_data_o=0.
- Access:
  - access = cpu_read_i | cpu_write_i.
  - If both are high, it is treated as a write and cpu_data_o=0.
  - hit = valid[idx] & (tag[idx] == addr tag).
- IDLE + hit read: cpu_data_o = data[idx][word] in the same cycle, stall=0, no memory traffic.
- IDLE + hit write: the word is written and dirty[idx] set at the next edge, stall=0.
- IDLE + miss:
  - cpu_stall_o=1 combinationally.
  - Next state is WB if valid & dirty, else FILL; counter=0.
  - cpu_data_o=0 when there is no hit read.
- WB:
  - mem_req_o=1, mem_we_o=1, mem_addr_o = {stored tag, idx, counter, 2'b00}, mem_data_o = data[idx][counter]; stall=1.
  - On an edge with mem_ack_i=1: counter++. After counter==3 is acked: counter=0, dirty cleared, go to FILL.
- FILL:
  - mem_req_o=1, mem_we_o=0, mem_addr_o = {cpu tag, idx, counter, 2'b00}; stall=1.
  - On an ack: data[idx][counter] = mem_data_i, counter++.
  - On the last ack: tag written, valid=1, dirty=0, go to IDLE.
  - The retried access hits in the next cycle; a retried write then sets dirty.
- Handshake:
  - While mem_req_o=1, mem_addr_o, mem_we_o and mem_data_o are stable until an ack edge.
  - mem_req_o may stay high across consecutive words, with the address advancing after each ack.
  - Any number of wait cycles is legal.
  - mem_ack_i is ignored while mem_req_o=0.
  - mem_req_o is 0 in IDLE.
- CPU inputs must stay stable while cpu_stall_o=1; any change is undefined.
- Reset mid-burst:
  - mem_req_o drops immediately and the line stays invalid.
  - Partial memory writes from an aborted WB are not undone.
- A miss costs at least 4 (clean) or 8 (dirty) cycles plus ack latency, plus 1 retry cycle.

Optional Feature:
- Macro DCACHE_STATS_EN.
- When defined, adds output ports hit_count_o[31:0] and miss_count_o[31:0], both reset to 0 by rst_i.
  - hit_count_o: +1 on each IDLE cycle with access & hit, excluding the retry cycle immediately after a FILL completes.
  - miss_count_o: +1 on each IDLE cycle that starts a WB/FILL.
  - Both counters saturate at 0xFFFFFFFF.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Cold read 0x00000010, mem ack 2 cycles after each req -> stall=1; mem reads at 0x10, 0x14, 0x18, 0x1C; the retry cycle returns mem[0x10] with stall=0.
2. After test 1, read 0x00000014 -> cpu_data_o = mem[0x14] in the same cycle, stall=0, mem_req_o stays 0.
3. Write 0xDEADBEEF to 0x18 (hit), then read 0x118 (same index 1, tag 1) -> WB writes to 0x10..0x1C with 0x18 = 0xDEADBEEF, then FILL from 0x110..0x11C, then the read returns mem[0x118].
4. Clean conflict: read 0x218 after test 3 -> no write cycles (mem_we_o never 1), FILL from 0x210..0x21C only.
5. Cold read 0x40; assert rst_i=0 after the 2nd ack -> mem_req_o=0 asynchronously; after release, re-reading 0x40 misses and refills all 4 words.
6. With DCACHE_STATS_EN: miss 0x10, then hits on 0x10, 0x14, 0x18, then miss 0x118 -> hit_count_o=3, miss_count_o=2.
